// File: rtl/div_tick_pwm_pkg.sv
// Shared constants for the divided-clock tick and PWM block.
// Tap select codes, tap count and default PWM resolution.
package div_tick_pwm_pkg;

  localparam int NUM_TAPS = 4;
  localparam int DEF_W    = 4;

  localparam logic [1:0] TAP_DIV2  = 2'd0;
  localparam logic [1:0] TAP_DIV4  = 2'd1;
  localparam logic [1:0] TAP_DIV8  = 2'd2;
  localparam logic [1:0] TAP_DIV16 = 2'd3;

endpackage

// File: rtl/div_tick_pwm_edge.sv
// One tap: synchronizer chain, edge-history flop, rise detect.
// Runs regardless of enable so re-enable never sees a stale edge.
module tap_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tap,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tap};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/div_tick_pwm.sv
// Tick strobes from divided-clock taps and a tick-driven PWM.
// Duty changes only take effect at a period boundary.
module div_tick_pwm
  import div_tick_pwm_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_TAPS-1:0] div_taps,
  input  logic [1:0]          tap_sel,
  input  logic [W-1:0]        duty,
  input  logic                duty_load,
  output logic [NUM_TAPS-1:0] tick,
  output logic                pwm_out,
  output logic [W-1:0]        pwm_cnt,
  output logic                period_done,
  output logic                duty_pending
);

  logic [NUM_TAPS-1:0] rise;
  logic [W-1:0]        act_duty;
  logic [W-1:0]        pend_duty;
  logic [W-1:0]        duty_nxt;
  logic [W-1:0]        cnt_nxt;
  logic                sel_tick;
  logic                adv;
  logic                wrap;

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    tap_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .tap  (div_taps[i]),
      .rise (rise[i])
    );
  end

  assign sel_tick = rise[tap_sel];
  assign adv      = sel_tick & ena;
  assign wrap     = adv & (pwm_cnt == '1);
  assign cnt_nxt  = adv ? pwm_cnt + W'(1) : pwm_cnt;

  // A load in the wrap cycle bypasses the pending register.
  always_comb begin
    duty_nxt = act_duty;
    unique case (1'b1)
      wrap && duty_load:                  duty_nxt = duty;
      wrap && !duty_load && duty_pending: duty_nxt = pend_duty;
      default:                            duty_nxt = act_duty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick         <= '0;
      pwm_out      <= 1'b0;
      pwm_cnt      <= '0;
      period_done  <= 1'b0;
      duty_pending <= 1'b0;
      act_duty     <= '0;
      pend_duty    <= '0;
    end else begin
      tick        <= rise & {NUM_TAPS{ena}};
      period_done <= wrap;
      if (ena) begin
        pwm_cnt  <= cnt_nxt;
        act_duty <= duty_nxt;
        pwm_out  <= (cnt_nxt < duty_nxt);
      end
      if (duty_load) pend_duty <= duty;
      duty_pending <= wrap ? 1'b0 : (duty_pending | duty_load);
    end
  end

endmodule
